// File: rtl/ifu_pkg.sv
// Shared types and address-map constants for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_LO    = 32'h0000_3000;
  localparam logic [31:0] PC_HI    = 32'h0000_3FFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO with flush; entry 0 is the registered head.
module fetch_queue
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         enq,
  input  fetch_entry_t enq_entry,
  input  logic         deq,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fetch_entry_t e0;
  fetch_entry_t e1;

  // Flush wins over everything; a full queue may shift and refill in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({enq, deq})
        2'b11: begin
          if (count == 2'd2) begin
            e0 <= e1;
            e1 <= enq_entry;
          end else begin
            e0 <= enq_entry;
          end
        end
        2'b10: begin
          if (count == 2'd0) e0 <= enq_entry;
          else               e1 <= enq_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
  assign head       = e0;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, reads IM combinationally and feeds a
// two-entry queue toward decode; redirects flush, bad PCs yield a fault entry.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = ifu_pkg::RESET_PC,
  parameter logic [31:0] PC_LO    = ifu_pkg::PC_LO,
  parameter logic [31:0] PC_HI    = ifu_pkg::PC_HI
) (
  input  logic        clk,
  input  logic        reset,
  output logic [12:2] im_addr,
  input  logic [31:0] im_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  import ifu_pkg::*;

  logic [31:0]  fpc;
  logic [31:0]  fpc_nx;
  fetch_state_e state;
  fetch_state_e state_nx;
  logic [1:0]   count;
  logic         deq;
  logic         space;
  logic         bad;
  logic         enq;
  fetch_entry_t enq_entry;
  fetch_entry_t head;

  assign im_addr = fpc[12:2];
  assign deq     = out_valid & out_ready;
  assign space   = (count < 2'd2) | deq;
  assign bad     = (fpc < PC_LO) | (fpc > PC_HI) | (fpc[1:0] != 2'b00);

  assign enq_entry.pc    = fpc;
  assign enq_entry.instr = bad ? 32'd0 : im_dout;
  assign enq_entry.fault = bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc   <= RESET_PC;
      state <= FETCH;
    end else begin
      fpc   <= fpc_nx;
      state <= state_nx;
    end
  end

  // A fault entry parks the fetcher in HALT until a redirect restarts it.
  always_comb begin
    fpc_nx   = fpc;
    state_nx = state;
    enq      = 1'b0;
    if (redirect_valid) begin
      fpc_nx   = redirect_pc;
      state_nx = FETCH;
    end else if (state == FETCH && space) begin
      enq = 1'b1;
      if (bad) state_nx = HALT;
      else     fpc_nx   = fpc + 32'd4;
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .enq        (enq),
    .enq_entry  (enq_entry),
    .deq        (deq & ~redirect_valid),
    .count      (count),
    .head_valid (out_valid),
    .head       (head)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_fault = head.fault;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl; IM content is derived from the word address.
module tb_ifu_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [12:2] im_addr;
  logic [31:0] im_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  int nCompared;
  int nMismatched;
  logic [65:0] got;
  logic [65:0] want;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .im_addr        (im_addr),
    .im_dout        (im_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign im_dout = 32'hC0DE_0000 | {21'd0, im_addr};

  function automatic logic [31:0] expInstr(input logic [31:0] pc);
    return 32'hC0DE_0000 | {21'd0, pc[12:2]};
  endfunction

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = rdy;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got = {out_valid, out_fault, out_pc, out_instr};
    nCompared++;
    if (got !== 66'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs got %h want %h", got, 66'd0);
    end
    nCompared++;
    if (im_addr !== 11'h400) begin
      nMismatched++;
      $display("[TB] FAIL reset_im_addr got %h want %h", im_addr, 11'h400);
    end
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got  = {out_valid, out_fault, out_pc, out_instr};
      want = {1'b1, 1'b0, 32'h3000 + 32'(4 * i), expInstr(32'h3000 + 32'(4 * i))};
      nCompared++;
      if (got !== want) begin
        nMismatched++;
        $display("[TB] FAIL stream[%0d] got %h want %h", i, got, want);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got  = {out_valid, out_fault, out_pc, out_instr};
      want = {1'b1, 1'b0, 32'h3000, expInstr(32'h3000)};
      nCompared++;
      if (got !== want) begin
        nMismatched++;
        $display("[TB] FAIL bp_hold[%0d] got %h want %h", i, got, want);
      end
    end
    nCompared++;
    if (dut.u_queue.count !== 2'd2) begin
      nMismatched++;
      $display("[TB] FAIL bp_count got %0d want 2", dut.u_queue.count);
    end
    nCompared++;
    if (im_addr !== 11'h402) begin
      nMismatched++;
      $display("[TB] FAIL bp_im_addr got %h want %h", im_addr, 11'h402);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      got  = {out_valid, out_fault, out_pc, out_instr};
      want = {1'b1, 1'b0, 32'h3000 + 32'(4 * i), expInstr(32'h3000 + 32'(4 * i))};
      nCompared++;
      if (got !== want) begin
        nMismatched++;
        $display("[TB] FAIL bp_drain[%0d] got %h want %h", i, got, want);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_flush;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3100;
    out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL flush_valid got %b want 0", out_valid);
    end
    nCompared++;
    if (im_addr !== 11'h440) begin
      nMismatched++;
      $display("[TB] FAIL flush_im_addr got %h want %h", im_addr, 11'h440);
    end
    @(negedge clk);
    got  = {out_valid, out_fault, out_pc, out_instr};
    want = {1'b1, 1'b0, 32'h3100, expInstr(32'h3100)};
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL flush_target got %h want %h", got, want);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_misaligned_fault;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3002;
    @(negedge clk);
    redirect_valid = 1'b0;
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL mis_flush got %b want 0", out_valid);
    end
    @(negedge clk);
    got  = {out_valid, out_fault, out_pc, out_instr};
    want = {1'b1, 1'b1, 32'h3002, 32'd0};
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL mis_fault got %h want %h", got, want);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nCompared++;
      if (out_valid !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL mis_halt[%0d] got %b want 0", i, out_valid);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    got  = {out_valid, out_fault, out_pc, out_instr};
    want = {1'b1, 1'b0, 32'h3000, expInstr(32'h3000)};
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL mis_resume got %h want %h", got, want);
    end
  endtask

  task automatic test_pc_hi;
    logic [65:0] seq [3];
    seq[0] = {1'b1, 1'b0, 32'h3FF8, expInstr(32'h3FF8)};
    seq[1] = {1'b1, 1'b0, 32'h3FFC, expInstr(32'h3FFC)};
    seq[2] = {1'b1, 1'b1, 32'h4000, 32'd0};
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3FF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {out_valid, out_fault, out_pc, out_instr};
      nCompared++;
      if (got !== seq[i]) begin
        nMismatched++;
        $display("[TB] FAIL pchi[%0d] got %h want %h", i, got, seq[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nCompared++;
      if (out_valid !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL pchi_halt[%0d] got %b want 0", i, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    got = {out_valid, out_fault, out_pc, out_instr};
    nCompared++;
    if (got !== 66'd0) begin
      nMismatched++;
      $display("[TB] FAIL async_clear got %h want %h", got, 66'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    got  = {out_valid, out_fault, out_pc, out_instr};
    want = {1'b1, 1'b0, 32'h3000, expInstr(32'h3000)};
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL async_restart got %h want %h", got, want);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_misaligned_fault();
    test_pc_hi();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Fetch controller that sequences the instruction memory for the pipelined MIPS core. It owns the fetch PC, drives the IM word address, captures the combinational IM read into a 2-entry instruction queue, and presents instructions to decode through a valid/ready handshake. Branch and jump redirects flush the queue. Out-of-range or misaligned PCs produce a fault entry.

## Interface
- `RESET_PC`, default 32'h0000_3000, is the fetch PC after reset.
- `PC_LO`, default 32'h0000_3000, is the lowest legal fetch address.
- `PC_HI`, default 32'h0000_3FFC, is the highest legal fetch address.
- `clk` input, 1 bit: the single clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `im_addr` output, [12:2]: word address to IM, combinational `fpc[12:2]`.
- `im_dout` input, 32 bits: IM read data, valid in the same cycle as `im_addr`.
- `redirect_valid` input, 1 bit: branch/jump/restart request.
- `redirect_pc` input, 32 bits: target PC, sampled when `redirect_valid`=1.
- `out_valid` output, 1 bit: the queue head is valid.
- `out_ready` input, 1 bit: decode accepts the head this cycle.
- `out_instr` output, 32 bits: head instruction word.
- `out_pc` output, 32 bits: head PC.
- `out_fault` output, 1 bit: the head is a fetch fault. Its instr field is 0.

## Operation
- State registers:
  - `fpc` (32 bits).
  - Queue of 2 entries {pc, instr, fault} with `count` 0..2.
  - FSM {FETCH, HALT}.
- Reset values:
  - `fpc`=RESET_PC, `count`=0, state=FETCH.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_fault`=0.
- Dequeue (`deq`) = `out_valid & out_ready`.
- Space = (`count`<2) | `deq`. When full, a simultaneous dequeue and enqueue is permitted.
- `bad` = (`fpc`<PC_LO) | (`fpc`>PC_HI) | (`fpc[1:0]`!=0).
- FETCH, no redirect, space=1:
  - `bad`=0: enqueue {fpc, im_dout, 0} and set `fpc`+=4.
  - `bad`=1: enqueue {fpc, 0, 1}, hold `fpc`, go to HALT.
- FETCH with space=0: hold `fpc`; no enqueue.
- HALT: no enqueue, `fpc` held. Leave HALT only via redirect.
- Redirect, from either state, has top priority:
  - `count`<=0; any same-cycle dequeue is discarded, and `out_valid`=0 next cycle.
  - `fpc`<=`redirect_pc`; no enqueue that cycle; state<=FETCH.
- Sequential fetch past PC_HI (0x3FFC→0x4000) faults on the next enqueue. There is no wrap-around.
- 32-bit PC add; carry discarded.
- The queue is FIFO; `out_*` always reflect entry 0. Outputs are registered; the IM path is purely combinational.

## Timing
- Reset deassert at edge 0:
  - Edge 1 enqueues RESET_PC.
  - `out_valid`=1 with `out_pc`=0x3000 after edge 1.
- Steady state with `out_ready`=1: one instruction per cycle, PCs consecutive.
- Redirect asserted in cycle t:
  - Queue empty and `out_valid`=0 in cycle t+1; `im_addr`=target[12:2] in t+1.
  - Target instruction is valid in t+2.
- Backpressure (`out_ready`=0):
  - Fills 2 entries, then holds.
  - The head stays stable until accepted.
  - `fpc` stops at the first unfetched PC.
- A fault entry is delivered like any instruction. Nothing follows it until a redirect.
- Reset asserted mid-operation immediately clears all state; there is no pending enqueue.

## Structure
- Shared package `ifu_pkg`:
  - Constants RESET_PC, PC_LO, PC_HI.
  - `fetch_entry_t` typedef {pc[31:0], instr[31:0], fault}.
  - FSM state enum.
- Sub-module `fetch_queue`: a 2-entry FIFO with flush, enq/deq, `count`, and head outputs. The top level holds `fpc`, the FSM and the fault check.

## Test plan
- Reset, `out_ready`=1, IM[0x3000..0x300C]=A,B,C,D → `out_pc` 0x3000,0x3004,0x3008,0x300C on consecutive cycles with instrs A..D; first valid is 1 cycle after reset release.
- `out_ready`=0 for 5 cycles after reset → `count`=2, head stays 0x3000/A, `im_addr`=0x402 (PC 0x3008); releasing ready yields 0x3000, 0x3004, 0x3008 with no gaps or duplicates.
- Full queue, redirect to 0x3100 with `out_ready`=1 in the same cycle → the head is not counted as consumed; next cycle `out_valid`=0; following cycle `out_pc`=0x3100.
- Redirect to 0x3002 → a single entry with `out_fault`=1, `out_instr`=0, `out_pc`=0x3002; `out_valid`=0 afterwards; redirect to 0x3000 resumes normal fetch.
- Redirect to 0x3FF8, free-running → entries 0x3FF8 and 0x3FFC, then a fault at 0x4000, then HALT.
- Assert `reset` asynchronously mid-stream with 2 entries queued → `out_valid`=0 immediately; after release, fetch restarts at 0x3000.
